// File: rtl/br_ctrl.sv
// Branch/PC control stage: owns the fetch PC, sequences wrong-path flushes
// and end-of-program drain/halt. Optional taken-branch counter: BR_STATS_EN.
module br_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int OFF_W        = 6,
  parameter int FLUSH_CYCLES = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              jump_en_i,
  input  logic [OFF_W-1:0]  jump_offset_i,
  input  logic [ADDR_W-1:0] br_addr_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic              flush_o,
`ifdef BR_STATS_EN
  output logic [7:0]        taken_cnt_o,
`endif
  output logic              halted_o
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    DRAIN,
    HALT
  } state_t;

  state_t          state;
  logic [FW-1:0]   flush_cnt;
  logic [DW-1:0]   drain_cnt;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_sat;
  logic            pc_last;
  logic            accept;

  // Truncating the sign-extended offset keeps only the bits that matter mod 2^ADDR_W.
  assign target  = br_addr_i + ADDR_W'($signed(jump_offset_i));
  assign pc_last = (pc_o == {ADDR_W{1'b1}});
  assign pc_sat  = pc_last ? pc_o : pc_o + ADDR_W'(1);
  assign accept  = !stall_i && jump_en_i &&
                   (state == RUN || state == DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      pc_o       <= '0;
      pc_valid_o <= 1'b1;
      flush_o    <= 1'b0;
      halted_o   <= 1'b0;
      flush_cnt  <= '0;
      drain_cnt  <= '0;
    end else if (!stall_i) begin
      unique case (state)
        RUN: begin
          if (accept) begin
            pc_o      <= target;
            flush_o   <= 1'b1;
            flush_cnt <= FW'(FLUSH_CYCLES - 1);
            state     <= FLUSH;
          end else if (pc_last) begin
            pc_valid_o <= 1'b0;
            drain_cnt  <= DW'(DRAIN_CYCLES - 1);
            state      <= DRAIN;
          end else begin
            pc_o <= pc_o + ADDR_W'(1);
          end
        end
        FLUSH: begin
          pc_o <= pc_sat;
          if (flush_cnt == '0) begin
            flush_o <= 1'b0;
            state   <= RUN;
          end else begin
            flush_cnt <= flush_cnt - FW'(1);
          end
        end
        DRAIN: begin
          if (accept) begin
            pc_o       <= target;
            pc_valid_o <= 1'b1;
            flush_o    <= 1'b1;
            flush_cnt  <= FW'(FLUSH_CYCLES - 1);
            state      <= FLUSH;
          end else if (drain_cnt == '0) begin
            halted_o <= 1'b1;
            state    <= HALT;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        HALT: begin
          state <= HALT;
        end
      endcase
    end
  end

`ifdef BR_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_cnt_o <= '0;
    end else if (accept && taken_cnt_o != 8'hff) begin
      taken_cnt_o <= taken_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_br_ctrl.sv
// Self-checking bench for br_ctrl against a behavioural PC/flush/drain model.
// Scenario tasks plus a randomized run; BR_STATS_EN adds counter checks.
module tb_br_ctrl;
  localparam int AW = 4;
  localparam int OW = 6;
  localparam int FC = 2;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          jen = 1'b0;
  logic [OW-1:0] off = '0;
  logic [AW-1:0] addr = '0;
  logic [AW-1:0] pc;
  logic          pcv, fl, hl;
`ifdef BR_STATS_EN
  logic [7:0]    tcnt;
`endif
  logic [6:0]    obs;

  br_ctrl #(.ADDR_W(AW), .OFF_W(OW), .FLUSH_CYCLES(FC),
            .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .jump_en_i(jen),
    .jump_offset_i(off), .br_addr_i(addr), .pc_o(pc),
    .pc_valid_o(pcv), .flush_o(fl),
`ifdef BR_STATS_EN
    .taken_cnt_o(tcnt),
`endif
    .halted_o(hl));

  always #5 clk = ~clk;
  assign obs = {pc, pcv, fl, hl};

  int vectors = 0;
  int errors  = 0;

  // Model: remaining flush cycles, remaining invalid drain cycles, halted flag
  int m_pc, m_flush_left, m_drain_left, m_taken;
  bit m_valid, m_halted;

  function automatic int tgt(int a, int o);
    int s;
    s = a + ((o >= 32) ? o - 64 : o);
    return ((s % 16) + 16) % 16;
  endfunction

  function automatic logic [6:0] expv();
    return {4'(m_pc), m_valid, (m_flush_left > 0), m_halted};
  endfunction

  task automatic model_reset();
    m_pc = 0; m_valid = 1; m_halted = 0;
    m_flush_left = 0; m_drain_left = 0; m_taken = 0;
  endtask

  task automatic model_step(bit s, bit j, int o, int a);
    if (s || m_halted) return;
    if (m_flush_left > 0) begin
      m_pc = (m_pc < 15) ? m_pc + 1 : 15;
      m_flush_left--;
    end else if (j) begin
      m_pc = tgt(a, o); m_valid = 1; m_flush_left = FC;
      if (m_taken < 255) m_taken++;
    end else if (!m_valid) begin
      m_drain_left--;
      if (m_drain_left == 0) m_halted = 1;
    end else if (m_pc == 15) begin
      m_valid = 0; m_drain_left = DC;
    end else begin
      m_pc++;
    end
  endtask

  task automatic cycle(bit s, bit j, int o, int a);
    stall = s; jen = j; off = OW'(o); addr = AW'(a);
    @(posedge clk);
    model_step(s, j, o, a);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    stall = 0; jen = 0; rst = 1;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    model_reset();
    #1;
    vectors++;
    if (obs !== 7'b0000_100 || obs !== expv()) begin
      errors++;
      $display("FAIL reset: got %b want %b", obs, 7'b0000_100);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      cycle(0, 0, 0, 0);
      vectors++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL seq k=%0d: got %b want %b", k, obs, expv());
      end
    end
    vectors++;
    if (pc !== 4'd15 || pcv !== 1'b0 || hl !== 1'b1) begin
      errors++;
      $display("FAIL seq_halt: got pc=%0d v=%b h=%b want 15 0 1",
               pc, pcv, hl);
    end
  endtask

  task automatic test_backward_branch();
    logic [AW-1:0] want_pc [3];
    logic          want_fl [3];
    want_pc = '{4'd2, 4'd3, 4'd4};
    want_fl = '{1'b1, 1'b1, 1'b0};
    do_reset();
    repeat (3) cycle(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) cycle(0, 1, 6'b111101, 5);
      else cycle(0, 0, 0, 0);
      vectors++;
      if (pc !== want_pc[k] || fl !== want_fl[k] || obs !== expv()) begin
        errors++;
        $display("FAIL back k=%0d: got pc=%0d f=%b want pc=%0d f=%b",
                 k, pc, fl, want_pc[k], want_fl[k]);
      end
    end
  endtask

  task automatic test_wrap_target();
    logic [AW-1:0] want_pc [3];
    want_pc = '{4'd1, 4'd2, 4'd3};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      if (k == 0) cycle(0, 1, 3, 14);
      else if (k == 1) cycle(0, 1, 5, 9);
      else cycle(0, 0, 0, 0);
      vectors++;
      if (pc !== want_pc[k] || obs !== expv()) begin
        errors++;
        $display("FAIL wrap k=%0d: got pc=%0d want pc=%0d",
                 k, pc, want_pc[k]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (7) cycle(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cycle(1, 1, 2, 3);
      vectors++;
      if (pc !== 4'd7 || fl !== 1'b0 || obs !== expv()) begin
        errors++;
        $display("FAIL stall k=%0d: got pc=%0d f=%b want 7 0", k, pc, fl);
      end
    end
    cycle(0, 0, 0, 0);
    vectors++;
    if (pc !== 4'd8 || obs !== expv()) begin
      errors++;
      $display("FAIL stall_rel: got pc=%0d want 8", pc);
    end
  endtask

  task automatic test_drain_rescue();
    do_reset();
    repeat (18) cycle(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) cycle(0, 1, 51, 13);
      else cycle(0, 0, 0, 0);
      vectors++;
      if (pc !== 4'(k) || pcv !== 1'b1 || hl !== 1'b0 ||
          fl !== (k < 2) || obs !== expv()) begin
        errors++;
        $display("FAIL drain k=%0d: got %b want %b", k, obs, expv());
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    repeat (2) cycle(0, 0, 0, 0);
    cycle(0, 1, 4, 6);
    @(negedge clk);
    rst = 1;
    model_reset();
    #1;
    vectors++;
    if (obs !== 7'b0000_100 || obs !== expv()) begin
      errors++;
      $display("FAIL rst_flush: got %b want %b", obs, 7'b0000_100);
    end
`ifdef BR_STATS_EN
    vectors++;
    if (tcnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_cnt: got %0d want 0", tcnt);
    end
`endif
    @(negedge clk);
    rst = 0;
    cycle(0, 0, 0, 0);
    vectors++;
    if (pc !== 4'd1 || fl !== 1'b0 || obs !== expv()) begin
      errors++;
      $display("FAIL rst_resume: got %b want %b", obs, expv());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if (m_halted && $urandom_range(3) == 0) do_reset();
      cycle($urandom_range(3) == 0, $urandom_range(9) < 2,
            int'($urandom_range(63)), int'($urandom_range(15)));
      vectors++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL rand k=%0d: got %b want %b", k, obs, expv());
      end
`ifdef BR_STATS_EN
      vectors++;
      if (tcnt !== 8'(m_taken)) begin
        errors++;
        $display("FAIL rand_cnt k=%0d: got %0d want %0d", k, tcnt, m_taken);
      end
`endif
    end
  endtask

`ifdef BR_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int k = 0; k < 300 * (FC + 1); k++) begin
      cycle(0, 1, 0, 0);
    end
    vectors++;
    if (tcnt !== 8'd255 || m_taken != 255) begin
      errors++;
      $display("FAIL sat_cnt: got %0d want 255", tcnt);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_backward_branch();
    test_wrap_target();
    test_stall();
    test_drain_rescue();
    test_reset_mid_flush();
    test_random();
`ifdef BR_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
